// File: rtl/width_12to8_if.sv
// Byte-unpacker bus bundle: 12-bit word ingress and 8-bit byte egress, valid/ready on both sides.
//   valid_in/ready_in/data_in/flush_in : word side (master drives valid, data, flush)
//   valid_out/ready_out/data_out       : byte side (master accepts via ready_out)
interface width_12to8_if;
   logic        valid_in;
   logic        ready_in;
   logic [11:0] data_in;
   logic        flush_in;
   logic        valid_out;
   logic        ready_out;
   logic [7:0]  data_out;

   // Producer/consumer environment around the unpacker
   modport master (
      output valid_in, data_in, flush_in, ready_out,
      input  ready_in, valid_out, data_out
   );

   // The unpacker itself
   modport slave (
      input  valid_in, data_in, flush_in, ready_out,
      output ready_in, valid_out, data_out
   );
endinterface

// File: rtl/width_12to8.sv
// 12-bit word to 8-bit byte unpacker: two words become three bytes, MSB first.
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : width_12to8_if.slave (word ingress, byte egress, flush of a 4-bit residue)
module width_12to8 (
   input logic           clk,
   input logic           rst,
   width_12to8_if.slave  bus
);
   localparam int unsigned W_IN   = 12;
   localparam int unsigned W_OUT  = 8;
   localparam int unsigned W_NIB  = 4;
   localparam int unsigned W_BUF  = 24;
   localparam int unsigned W_FILL = 5;

   localparam logic [W_FILL-1:0] FILL_NIB  = W_FILL'(W_NIB);
   localparam logic [W_FILL-1:0] FILL_BYTE = W_FILL'(W_OUT);
   localparam logic [W_FILL-1:0] FILL_WORD = W_FILL'(W_IN);
   localparam logic [W_BUF-1:0]  INS_MASK  = {{W_IN{1'b1}}, {(W_BUF-W_IN){1'b0}}};

   logic [W_BUF-1:0]  sbuf_q, sbuf_d, sbuf_base;
   logic [W_FILL-1:0] fill_q, fill_d, fill_base;
   logic              valid_out_q, valid_out_d;
   logic [W_OUT-1:0]  data_out_q, data_out_d;
   logic              ready_in_q, ready_in_d;
   logic              acc, fr, pop, pad;

   // Next-state: drain a byte (or the padded residue) first, then append the accepted word
   always_comb begin
      sbuf_d      = sbuf_q;
      fill_d      = fill_q;
      valid_out_d = valid_out_q;
      data_out_d  = data_out_q;
      sbuf_base   = sbuf_q;
      fill_base   = fill_q;

      acc = bus.valid_in & ready_in_q;
      fr  = ~valid_out_q | bus.ready_out;
      pop = fr & (fill_q >= FILL_BYTE);
      pad = fr & (fill_q == FILL_NIB) & bus.flush_in & ~acc;

      if (pop) begin
         data_out_d  = sbuf_q[W_BUF-1 -: W_OUT];
         valid_out_d = 1'b1;
         sbuf_base   = sbuf_q << W_OUT;
         fill_base   = fill_q - FILL_BYTE;
      end else if (pad) begin
         data_out_d  = {sbuf_q[W_BUF-1 -: W_NIB], W_NIB'(0)};
         valid_out_d = 1'b1;
         sbuf_base   = '0;
         fill_base   = '0;
      end else if (fr) begin
         valid_out_d = 1'b0;
      end

      sbuf_d = sbuf_base;
      fill_d = fill_base;
      // New word lands directly below the remaining valid bits; stale bits there are cleared
      if (acc) begin
         sbuf_d = (sbuf_base & ~(INS_MASK >> fill_base))
                | ({bus.data_in, W_IN'(0)} >> fill_base);
         fill_d = fill_base + FILL_WORD;
      end

      // Room for a full word next cycle; a pure function of the next fill level
      ready_in_d = (fill_d <= FILL_WORD);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sbuf_q      <= '0;
         fill_q      <= '0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
         ready_in_q  <= 1'b1;
      end else begin
         sbuf_q      <= sbuf_d;
         fill_q      <= fill_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         ready_in_q  <= ready_in_d;
      end
   end

   assign bus.ready_in  = ready_in_q;
   assign bus.valid_out = valid_out_q;
   assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_width_12to8.sv
// Bench for width_12to8: nibble-queue reference model, per-cycle compare, directed and random stimulus.
module tb_width_12to8;
   logic clk;
   logic rst;
   width_12to8_if ifc ();

   width_12to8 dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference: pending bits as a queue of nibbles plus an output holding register
   logic [3:0] nq[$];
   logic       mv = 1'b0;
   logic [7:0] md = 8'h00;
   logic       m_acc, m_fr;

   // Bytes handshaken by the consumer, with the cycle they were offered
   logic [7:0] log_b[$];
   int         log_c[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model advance on each clock edge, from the inputs held across that edge
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         nq.delete();
         mv = 1'b0;
         md = 8'h00;
      end else begin
         m_acc = ifc.valid_in && (nq.size() <= 3);
         m_fr  = !mv || ifc.ready_out;
         if (m_fr && nq.size() >= 2) begin
            md = {nq[0], nq[1]};
            void'(nq.pop_front());
            void'(nq.pop_front());
            mv = 1'b1;
         end else if (m_fr && nq.size() == 1 && ifc.flush_in && !m_acc) begin
            md = {nq[0], 4'h0};
            void'(nq.pop_front());
            mv = 1'b1;
         end else if (m_fr) begin
            mv = 1'b0;
         end
         if (m_acc) begin
            nq.push_back(ifc.data_in[11:8]);
            nq.push_back(ifc.data_in[7:4]);
            nq.push_back(ifc.data_in[3:0]);
         end
      end
   end

   // Compare process: every cycle on the falling edge
   always @(negedge clk) begin
      chk("ready_in", 32'(ifc.ready_in), 32'(nq.size() <= 3));
      chk("valid_out", 32'(ifc.valid_out), 32'(mv));
      if (mv) chk("data_out", 32'(ifc.data_out), 32'(md));
      if (ifc.valid_out === 1'b1 && ifc.ready_out === 1'b1 && !rst) begin
         log_b.push_back(ifc.data_out);
         log_c.push_back(cyc);
      end
   end

   task automatic step(input logic v, input logic [11:0] d, input logic f,
                       input logic ro, input logic r);
      ifc.valid_in  = v;
      ifc.data_in   = d;
      ifc.flush_in  = f;
      ifc.ready_out = ro;
      rst           = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic chk_log(input string name, input logic [7:0] exp[$]);
      chk({name, "_count"}, 32'(log_b.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         if (i < log_b.size()) chk(name, 32'(log_b[i]), 32'(exp[i]));
   endtask

   logic [11:0] words[6];
   logic [7:0]  exp_b[$];
   int          idx;
   logic        rdy;

   initial begin
      ifc.valid_in  = 1'b0;
      ifc.data_in   = 12'h000;
      ifc.flush_in  = 1'b0;
      ifc.ready_out = 1'b0;
      rst           = 1'b1;

      // Reset
      step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
      step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      chk("rst_valid_out", 32'(ifc.valid_out), 32'h0);
      chk("rst_data_out", 32'(ifc.data_out), 32'h00);
      chk("rst_ready_in", 32'(ifc.ready_in), 32'h1);

      // Two words back-to-back
      log_b.delete(); log_c.delete();
      step(1'b1, 12'hABC, 1'b0, 1'b1, 1'b0);
      step(1'b1, 12'hDEF, 1'b0, 1'b1, 1'b0);
      chk("t2_ready_at_fill16", 32'(ifc.ready_in), 32'h0);
      idle(4);
      exp_b = '{8'hAB, 8'hCD, 8'hEF};
      chk_log("t2_byte", exp_b);
      if (log_c.size() == 3) chk("t2_consecutive", 32'(log_c[2] - log_c[0]), 32'd2);

      // Six-word stream, valid held high
      for (int i = 0; i < 6; i++) words[i] = 12'($urandom);
      log_b.delete(); log_c.delete();
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         rdy = ifc.ready_in;
         step(1'b1, words[idx], 1'b0, 1'b1, 1'b0);
         if (rdy) idx++;
      end
      chk("t3_words_taken", 32'(idx), 32'd6);
      idle(6);
      exp_b.delete();
      for (int p = 0; p < 6; p += 2) begin
         exp_b.push_back(words[p] >> 4);
         exp_b.push_back(8'(((words[p] & 12'h00F) << 4) | (words[p+1] >> 8)));
         exp_b.push_back(8'(words[p+1] & 12'h0FF));
      end
      chk_log("t3_byte", exp_b);
      if (log_c.size() == 9) chk("t3_no_gaps", 32'(log_c[8] - log_c[0]), 32'd8);

      // Backpressure
      log_b.delete(); log_c.delete();
      step(1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
      step(1'b1, 12'h456, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
      chk("t4_hold_data", 32'(ifc.data_out), 32'h12);
      chk("t4_hold_valid", 32'(ifc.valid_out), 32'h1);
      chk("t4_ready_full", 32'(ifc.ready_in), 32'h0);
      idle(5);
      exp_b = '{8'h12, 8'h34, 8'h56};
      chk_log("t4_byte", exp_b);

      // Flush of a residue, then flush with nothing pending
      log_b.delete(); log_c.delete();
      step(1'b1, 12'h9A5, 1'b0, 1'b1, 1'b0);
      step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
      step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
      idle(3);
      chk("t5_ready_after", 32'(ifc.ready_in), 32'h1);
      step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
      idle(3);
      exp_b = '{8'h9A, 8'h50};
      chk_log("t5_byte", exp_b);

      // Mid-operation reset discards the residue
      log_b.delete(); log_c.delete();
      step(1'b1, 12'h777, 1'b0, 1'b1, 1'b0);
      step(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
      chk("t6_valid_after_rst", 32'(ifc.valid_out), 32'h0);
      step(1'b1, 12'h111, 1'b0, 1'b1, 1'b0);
      step(1'b1, 12'h222, 1'b0, 1'b1, 1'b0);
      idle(5);
      exp_b = '{8'h11, 8'h12, 8'h22};
      chk_log("t6_byte", exp_b);

      // Random traffic, flushes, stalls and occasional resets
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, 12'($urandom), ($urandom % 4) == 0,
              ($urandom % 4) != 0, ($urandom % 200) == 0);
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
